// File: rtl/mem_bus_arbiter.sv
// Two-master (instruction fetch, data) to one-slave Avalon-MM bus arbiter.
// Round-robin or fixed data-priority; the grant is held until the owner's transfer completes.
module mem_bus_arbiter #(
    parameter bit FIXED_PRIORITY = 1'b0
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] i_address,
    input  logic        i_read,
    output logic        i_waitrequest,
    output logic [31:0] i_readdata,

    input  logic [31:0] d_address,
    input  logic        d_read,
    input  logic        d_write,
    input  logic [31:0] d_writedata,
    input  logic [3:0]  d_byteenable,
    output logic        d_waitrequest,
    output logic [31:0] d_readdata,

    output logic [31:0] mem_address,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_writedata,
    output logic [3:0]  mem_byteenable,
    input  logic        mem_waitrequest,
    input  logic [31:0] mem_readdata,

    output logic [1:0]  grant
);

    // Handshake: a master holds its request and address/data stable while its
    // waitrequest is 1; the transfer completes in the cycle its waitrequest is 0.
    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        GRANT_I = 2'b01,
        GRANT_D = 2'b10
    } state_t;

    typedef enum logic {
        PRIO_I = 1'b0,
        PRIO_D = 1'b1
    } prio_t;

    state_t state;
    prio_t  prio;

    logic req_i;
    logic req_d;
    logic i_wins;

    assign req_i = i_read;
    assign req_d = d_read | d_write;

    // I takes the bus when alone, or on a tie when it holds the round-robin turn.
    assign i_wins = req_i && (!req_d || (!FIXED_PRIORITY && prio == PRIO_I));

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            prio  <= PRIO_I;
            grant <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (i_wins) begin
                        state <= GRANT_I;
                        grant <= 2'b01;
                    end else if (req_d) begin
                        state <= GRANT_D;
                        grant <= 2'b10;
                    end
                end
                GRANT_I: begin
                    if (!req_i || !mem_waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        if (req_i && !FIXED_PRIORITY) begin
                            prio <= PRIO_D;
                        end
                    end
                end
                GRANT_D: begin
                    if (!req_d || !mem_waitrequest) begin
                        state <= IDLE;
                        grant <= 2'b00;
                        if (req_d && !FIXED_PRIORITY) begin
                            prio <= PRIO_I;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    grant <= 2'b00;
                end
            endcase
        end
    end

    always_comb begin
        mem_address    = 32'h0;
        mem_read       = 1'b0;
        mem_write      = 1'b0;
        mem_writedata  = 32'h0;
        mem_byteenable = 4'h0;
        i_waitrequest  = 1'b1;
        d_waitrequest  = 1'b1;
        case (state)
            GRANT_I: begin
                mem_address    = i_address;
                mem_read       = i_read;
                mem_byteenable = 4'hF;
                i_waitrequest  = mem_waitrequest;
            end
            GRANT_D: begin
                // A simultaneous read+write from the data port is issued as a write.
                mem_address    = d_address;
                mem_write      = d_write;
                mem_read       = d_read & ~d_write;
                mem_writedata  = d_writedata;
                mem_byteenable = d_byteenable;
                d_waitrequest  = mem_waitrequest;
            end
            default: begin
                mem_address = 32'h0;
            end
        endcase
    end

    assign i_readdata = mem_readdata;
    assign d_readdata = mem_readdata;

endmodule
